// File: rtl/sonic_rx_write_address.sv
`timescale 1ns/1ps
// RX ring write-address generator: address per accepted word, occupancy vs host rd_ptr, block-done pulses; SONIC_RX_OVERFLOW_CNT_EN adds a stall counter.
// Address, blk_done and flags land 1 cycle after accept; wr_ready is registered and drops before the ring can overrun.
module sonic_rx_write_address #(
   parameter int            AW         = 14,
   parameter logic [AW-1:0] DEPTH      = 14'h3E00,
   parameter logic [AW-1:0] BLOCK_SIZE = 14'd496
) (
   input  logic          clk_in,
   input  logic          reset_n,
   input  logic          ena,
   input  logic          wr_valid,
   output logic          wr_ready,
   output logic [AW-1:0] addr_out,
   output logic          addr_valid,
   input  logic [AW-1:0] rd_ptr_in,
   input  logic          rd_ptr_load,
   output logic [AW:0]   occupancy,
   output logic          full,
   output logic          empty,
   output logic          blk_done,
   output logic [AW-1:0] blk_idx
`ifdef SONIC_RX_OVERFLOW_CNT_EN
   ,
   input  logic          ovf_clr,
   output logic [15:0]   ovf_cnt
`endif
);

   localparam logic [AW-1:0] LAST_PTR = DEPTH - 1'b1;
   localparam logic [AW-1:0] LAST_OFF = BLOCK_SIZE - 1'b1;
   localparam logic [AW-1:0] LAST_BLK = DEPTH / BLOCK_SIZE - 1'b1;
   localparam logic [AW:0]   DEPTH_W  = {1'b0, DEPTH};

   typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

   state_t        state;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] blk_off;
   logic [AW-1:0] blk_cnt;
   logic          accept;
   logic          load_ok;
   logic [AW+1:0] freed;
   logic [AW+1:0] occ_sum;
   logic [AW:0]   occ_next;

   always_comb begin
      accept  = wr_valid & wr_ready;
      load_ok = rd_ptr_load && (rd_ptr_in < DEPTH);
      freed   = '0;
      if (load_ok) begin
         if (rd_ptr_in >= rd_ptr)
            freed = {2'b00, rd_ptr_in} - {2'b00, rd_ptr};
         else
            freed = {2'b00, rd_ptr_in} + {2'b00, DEPTH} - {2'b00, rd_ptr};
      end
      occ_sum = {1'b0, occupancy} + {{(AW+1){1'b0}}, accept};
      // A host pointer that runs past the writer clamps to empty.
      occ_next = (freed > occ_sum) ? '0 : (AW+1)'(occ_sum - freed);
   end

   assign full  = (occupancy == DEPTH_W);
   assign empty = (occupancy == '0);

   always_ff @(posedge clk_in) begin
      if (!reset_n) begin
         state      <= IDLE;
         wr_ready   <= 1'b0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         addr_out   <= '0;
         addr_valid <= 1'b0;
         blk_done   <= 1'b0;
         blk_idx    <= '0;
         blk_off    <= '0;
         blk_cnt    <= '0;
      end else begin
         addr_valid <= accept;
         blk_done   <= 1'b0;
         if (accept) begin
            addr_out <= wr_ptr;
            wr_ptr   <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            // Block position is tracked incrementally; BLOCK_SIZE divides DEPTH so it realigns at wrap.
            if (blk_off == LAST_OFF) begin
               blk_off  <= '0;
               blk_done <= 1'b1;
               blk_idx  <= blk_cnt;
               blk_cnt  <= (blk_cnt == LAST_BLK) ? '0 : blk_cnt + 1'b1;
            end else begin
               blk_off <= blk_off + 1'b1;
            end
         end
         if (load_ok)
            rd_ptr <= rd_ptr_in;
         occupancy <= occ_next;

         case (state)
            IDLE: begin
               if (ena && occ_next == DEPTH_W) begin
                  state    <= HOLD;
                  wr_ready <= 1'b0;
               end else if (ena) begin
                  state    <= RUN;
                  wr_ready <= 1'b1;
               end else begin
                  wr_ready <= 1'b0;
               end
            end
            RUN: begin
               if (!ena) begin
                  state    <= IDLE;
                  wr_ready <= 1'b0;
               end else if (occ_next == DEPTH_W) begin
                  state    <= HOLD;
                  wr_ready <= 1'b0;
               end else begin
                  wr_ready <= 1'b1;
               end
            end
            HOLD: begin
               if (!ena) begin
                  state    <= IDLE;
                  wr_ready <= 1'b0;
               end else if (occ_next < DEPTH_W) begin
                  state    <= RUN;
                  wr_ready <= 1'b1;
               end else begin
                  wr_ready <= 1'b0;
               end
            end
            default: begin
               state    <= IDLE;
               wr_ready <= 1'b0;
            end
         endcase
      end
   end

`ifdef SONIC_RX_OVERFLOW_CNT_EN
   always_ff @(posedge clk_in) begin
      if (!reset_n)
         ovf_cnt <= '0;
      else if (ovf_clr)
         ovf_cnt <= '0;
      else if (wr_valid && !wr_ready && state != IDLE && ovf_cnt != 16'hFFFF)
         ovf_cnt <= ovf_cnt + 16'd1;
   end
`endif

endmodule

// File: tb/tb_sonic_rx_write_address.sv
`timescale 1ns/1ps
// Randomized scoreboard bench for sonic_rx_write_address against a count-based ring model.
module tb_sonic_rx_write_address;
   localparam int AW    = 14;
   localparam int DEPTH = 15872;
   localparam int BLK   = 496;

   logic          clk_in = 1'b0;
   logic          reset_n, ena, wr_valid, wr_ready, addr_valid, rd_ptr_load, full, empty, blk_done;
   logic [AW-1:0] addr_out, rd_ptr_in, blk_idx;
   logic [AW:0]   occupancy;
`ifdef SONIC_RX_OVERFLOW_CNT_EN
   logic          ovf_clr;
   logic [15:0]   ovf_cnt;
`endif

   always #5 clk_in = ~clk_in;

   sonic_rx_write_address dut (
      .clk_in(clk_in), .reset_n(reset_n), .ena(ena), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .addr_out(addr_out), .addr_valid(addr_valid), .rd_ptr_in(rd_ptr_in), .rd_ptr_load(rd_ptr_load),
      .occupancy(occupancy), .full(full), .empty(empty), .blk_done(blk_done), .blk_idx(blk_idx)
`ifdef SONIC_RX_OVERFLOW_CNT_EN
      , .ovf_clr(ovf_clr), .ovf_cnt(ovf_cnt)
`endif
   );

   typedef struct { int addr; bit blk; int idx; } exp_t;
   exp_t exp_q[$];

   int n_checks = 0;
   int n_fail   = 0;
   int m_occ, m_rdp, m_waddr, m_total, m_ovf, dut_acc, seen31, seen0;
   bit m_ready, m_nonidle, m_was_rst;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One cycle: compare visible outputs with the model, drive inputs, then advance the model.
   task automatic step(input bit rst, input bit e, input bit v, input bit ld, input int rin, input bit clr);
      int acc, fr, sum;
      @(negedge clk_in);
      check("wr_ready", wr_ready, m_ready);
      check("occupancy", occupancy, m_occ);
      check("full", full, m_occ == DEPTH);
      check("empty", empty, m_occ == 0);
`ifdef SONIC_RX_OVERFLOW_CNT_EN
      check("ovf_cnt", ovf_cnt, m_ovf);
`endif
      if (m_was_rst) begin
         check("rst_addr_out", addr_out, 0);
         check("rst_blk_idx", blk_idx, 0);
         check("rst_addr_valid", addr_valid, 0);
         check("rst_blk_done", blk_done, 0);
      end
      reset_n     = !rst;
      ena         = e;
      wr_valid    = v;
      rd_ptr_load = ld;
      rd_ptr_in   = rin[AW-1:0];
`ifdef SONIC_RX_OVERFLOW_CNT_EN
      ovf_clr     = clr;
`endif
      if (v && wr_ready === 1'b1) dut_acc++;
      m_was_rst = rst;
      if (rst) begin
         m_occ = 0; m_rdp = 0; m_waddr = 0; m_total = 0;
         m_ready = 0; m_nonidle = 0; m_ovf = 0; dut_acc = 0;
      end else begin
         acc = (v && m_ready) ? 1 : 0;
         if (acc != 0) begin
            exp_q.push_back('{m_waddr, ((m_waddr + 1) % BLK) == 0, m_waddr / BLK});
            m_waddr = (m_waddr + 1) % DEPTH;
            m_total++;
         end
         fr = (ld && rin < DEPTH) ? (rin - m_rdp + DEPTH) % DEPTH : 0;
         if (ld && rin < DEPTH) m_rdp = rin;
         sum   = m_occ + acc - fr;
         m_occ = (sum < 0) ? 0 : sum;
         if (clr) m_ovf = 0;
         else if (v && !m_ready && m_nonidle && m_ovf < 65535) m_ovf++;
         m_ready   = e && (m_occ < DEPTH);
         m_nonidle = e;
      end
   endtask

   // Monitor: pops one expectation per addr_valid pulse.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk_in); #1;
         if (addr_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
               check("addr_valid_unexpected", addr_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("addr_out", addr_out, e.addr);
               check("blk_done", blk_done, e.blk);
               if (e.blk) check("blk_idx", blk_idx, e.idx);
            end
         end else begin
            check("addr_valid", addr_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
            check("blk_done_idle", blk_done, 0);
         end
         if (blk_done === 1'b1 && blk_idx == 31) seen31++;
         if (blk_done === 1'b1 && blk_idx == 0) seen0++;
      end
   end

   initial begin
      int r, rin, adv;
      bit ld;
      reset_n = 0; ena = 0; wr_valid = 0; rd_ptr_load = 0; rd_ptr_in = '0;
`ifdef SONIC_RX_OVERFLOW_CNT_EN
      ovf_clr = 0;
`endif
      m_occ = 0; m_rdp = 0; m_waddr = 0; m_total = 0; m_ovf = 0;
      m_ready = 0; m_nonidle = 0; m_was_rst = 0; dut_acc = 0; seen31 = 0; seen0 = 0;

      // Reset, then five back-to-back writes.
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      repeat (5) step(0, 1, 1, 0, 0, 0);
      @(posedge clk_in); #1;
      check("five_occ", occupancy, 5);
      check("five_empty", empty, 0);

      // Long run with host tracking, crossing the wrap point.
      step(1, 1, 0, 0, 0, 0);
      seen31 = 0; seen0 = 0;
      for (int i = 0; i < 30000 && m_total < DEPTH + 600; i++) begin
         ld  = ($urandom_range(0, 1) == 1);
         adv = (m_occ > 0) ? $urandom_range(0, m_occ) : 0;
         step(0, 1, $urandom_range(0, 9) != 0, ld, (m_rdp + adv) % DEPTH, 0);
      end
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("wrap_blk31_count", seen31, 1);
      check("wrap_blk0_count", seen0, 2);

      // Simultaneous accept and free.
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 300 && m_occ < 100; i++) step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 1, 40, 0);
      @(posedge clk_in); #1;
      check("acc_and_load_occ", occupancy, 61);

      // Reset in the middle of a block.
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 600 && m_waddr < 300; i++) step(0, 1, $urandom_range(0, 3) != 0, 0, 0, 0);
      @(posedge clk_in); #1;
      check("pre_reset_occ", occupancy, 300);
      step(1, 1, 1, 0, 0, 0);
      repeat (4) step(0, 1, 1, 0, 0, 0);

      // Fill the ring from empty, then free ten entries.
      step(1, 1, 0, 0, 0, 0);
      for (int i = 0; i < 17000 && m_occ < DEPTH; i++) step(0, 1, 1, 0, 0, 0);
      step(0, 1, 1, 0, 0, 1);
      repeat (7) step(0, 1, 1, 0, 0, 0);
      @(posedge clk_in); #1;
      check("fill_accepts", dut_acc, DEPTH);
      check("fill_full", full, 1);
      check("fill_ready", wr_ready, 0);
      check("fill_occ", occupancy, DEPTH);
`ifdef SONIC_RX_OVERFLOW_CNT_EN
      check("ovf_seven", ovf_cnt, 7);
      step(0, 1, 1, 0, 0, 1);
      @(posedge clk_in); #1;
      check("ovf_clr_prio", ovf_cnt, 0);
`endif
      step(0, 1, 1, 1, 10, 0);
      @(posedge clk_in); #1;
      check("free10_occ", occupancy, DEPTH - 10);
      check("free10_ready", wr_ready, 1);

      // Random mix: ena toggles, illegal / no-op / overrun loads, occasional reset.
      for (int i = 0; i < 3000; i++) begin
         r  = $urandom_range(0, 99);
         ld = ($urandom_range(0, 3) == 0);
         if (r < 10)      rin = DEPTH + $urandom_range(0, 511);
         else if (r < 20) rin = m_rdp;
         else if (r < 30) rin = (m_rdp + m_occ + $urandom_range(1, 50)) % DEPTH;
         else             rin = (m_rdp + $urandom_range(0, m_occ)) % DEPTH;
         step($urandom_range(0, 499) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
              ld, rin, $urandom_range(0, 19) == 0);
      end
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      check("queue_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
